// File: rtl/msp430_pkg.sv
// Shared MSP430 double-operand definitions: opcodes, ALU selects, FSM states, flag indices.
// Pure declarations; no timing or backpressure of its own.
package msp430_pkg;

    localparam logic [3:0] OP_MOV = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_BIT = 4'hB;
    localparam logic [3:0] OP_BIC = 4'hC;
    localparam logic [3:0] OP_BIS = 4'hD;
    localparam logic [3:0] OP_XOR = 4'hE;
    localparam logic [3:0] OP_AND = 4'hF;

    // ALU select encodings; the ALU decodes the same constants.
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00011;
    localparam logic [4:0] ALU_XOR = 5'b00100;
    localparam logic [4:0] ALU_BIT = 5'b00110;
    localparam logic [4:0] ALU_BIC = 5'b00111;
    localparam logic [4:0] ALU_BIS = 5'b01000;
    localparam logic [4:0] ALU_CMP = 5'b01001;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_SRC = 3'd1,
        ST_RD_DST = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FM_NONE  = 2'd0,
        FM_ARITH = 2'd1,
        FM_LOGIC = 2'd2
    } flag_mode_t;

    typedef struct packed {
        logic       legal;
        logic [4:0] alu_sel;
        logic       writes_dst;
        flag_mode_t flag_mode;
        logic       bw;
    } dec_t;

endpackage

// File: rtl/msp430_dop_decode.sv
// Combinational decode of a double-operand instruction word into control fields.
// Zero latency; no handshake, the caller samples the result when it accepts the word.
module msp430_dop_decode
    import msp430_pkg::*;
(
    input  logic [15:0] instr_i,
    output dec_t        dec_o
);

    logic [3:0] opcode;

    assign opcode = instr_i[15:12];

    always_comb begin
        dec_o           = '0;
        dec_o.bw        = instr_i[6];
        dec_o.flag_mode = FM_NONE;
        unique case (opcode)
            OP_MOV: begin
                dec_o.legal      = 1'b1;
                dec_o.writes_dst = 1'b1;
            end
            OP_ADD: begin
                dec_o.legal      = 1'b1;
                dec_o.alu_sel    = ALU_ADD;
                dec_o.writes_dst = 1'b1;
                dec_o.flag_mode  = FM_ARITH;
            end
            OP_SUB: begin
                dec_o.legal      = 1'b1;
                dec_o.alu_sel    = ALU_SUB;
                dec_o.writes_dst = 1'b1;
                dec_o.flag_mode  = FM_ARITH;
            end
            OP_CMP: begin
                dec_o.legal      = 1'b1;
                dec_o.alu_sel    = ALU_CMP;
                dec_o.flag_mode  = FM_ARITH;
            end
            OP_BIT: begin
                dec_o.legal      = 1'b1;
                dec_o.alu_sel    = ALU_BIT;
                dec_o.flag_mode  = FM_LOGIC;
            end
            OP_BIC: begin
                dec_o.legal      = 1'b1;
                dec_o.alu_sel    = ALU_BIC;
                dec_o.writes_dst = 1'b1;
            end
            OP_BIS: begin
                dec_o.legal      = 1'b1;
                dec_o.alu_sel    = ALU_BIS;
                dec_o.writes_dst = 1'b1;
            end
            OP_XOR: begin
                dec_o.legal      = 1'b1;
                dec_o.alu_sel    = ALU_XOR;
                dec_o.writes_dst = 1'b1;
                dec_o.flag_mode  = FM_LOGIC;
            end
            OP_AND: begin
                dec_o.legal      = 1'b1;
                dec_o.alu_sel    = ALU_AND;
                dec_o.writes_dst = 1'b1;
                dec_o.flag_mode  = FM_LOGIC;
            end
            default: dec_o.legal = 1'b0;
        endcase
        // Only register-direct addressing is implemented.
        if (instr_i[7] || (instr_i[5:4] != 2'b00)) begin
            dec_o.legal = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multicycle issue controller: reads src/dst from the register file, drives the ALU, writes back result and flags.
// Legal instruction done 4 cycles after accept (illegal: 1); instr_ready only in IDLE, no queueing.
module alu_issue_ctrl
    import msp430_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  rf_raddr,
    input  logic [15:0] rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_sel,
    input  logic [15:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  sr_flags,
    output logic        done,
    output logic        err
);

    state_t      state_q, state_d;
    dec_t        dec_in, dec_q;
    logic [3:0]  opc_q, rsrc_q, rdst_q;
    logic [15:0] src_q, result_q;
    logic [3:0]  sr_flags_q, new_flags;

    logic [15:0] src_op, dst_op, exec_val, wb_val;
    logic        res_n, res_z, swap_ops;

    msp430_dop_decode u_decode (
        .instr_i (instr),
        .dec_o   (dec_in)
    );

    // Datapath seen during EXEC: rf_rdata carries the destination register there.
    always_comb begin
        src_op   = dec_q.bw ? {8'h00, src_q[7:0]}    : src_q;
        dst_op   = dec_q.bw ? {8'h00, rf_rdata[7:0]} : rf_rdata;
        swap_ops = (opc_q == OP_BIC);
        exec_val = (opc_q == OP_MOV) ? src_op : alu_result;
        wb_val   = dec_q.bw ? {8'h00, exec_val[7:0]} : exec_val;
        res_n    = dec_q.bw ? wb_val[7] : wb_val[15];
        res_z    = (wb_val == 16'h0000);
    end

    always_comb begin
        new_flags = sr_flags_q;
        unique case (dec_q.flag_mode)
            FM_ARITH: begin
                new_flags = alu_flags;
                if (dec_q.bw) begin
                    new_flags[FLAG_N] = res_n;
                    new_flags[FLAG_Z] = res_z;
                end
            end
            FM_LOGIC: begin
                new_flags[FLAG_N] = res_n;
                new_flags[FLAG_Z] = res_z;
                new_flags[FLAG_C] = ~res_z;
                new_flags[FLAG_V] = 1'b0;
            end
            default: new_flags = sr_flags_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        rf_raddr    = 4'h0;
        rf_we       = 1'b0;
        rf_waddr    = 4'h0;
        rf_wdata    = 16'h0000;
        alu_a       = 16'h0000;
        alu_b       = 16'h0000;
        alu_sel     = 5'b00000;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = dec_in.legal ? ST_RD_SRC : ST_ERR;
                end
            end
            ST_RD_SRC: begin
                rf_raddr = rsrc_q;
                state_d  = ST_RD_DST;
            end
            ST_RD_DST: begin
                rf_raddr = rdst_q;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                alu_a   = swap_ops ? src_op : dst_op;
                alu_b   = swap_ops ? dst_op : src_op;
                alu_sel = dec_q.alu_sel;
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we    = dec_q.writes_dst;
                rf_waddr = rdst_q;
                rf_wdata = result_q;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dec_q      <= '0;
            opc_q      <= 4'h0;
            rsrc_q     <= 4'h0;
            rdst_q     <= 4'h0;
            src_q      <= 16'h0000;
            result_q   <= 16'h0000;
            sr_flags_q <= 4'h0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && instr_valid) begin
                dec_q  <= dec_in;
                opc_q  <= instr[15:12];
                rsrc_q <= instr[11:8];
                rdst_q <= instr[3:0];
            end
            if (state_q == ST_RD_DST) begin
                src_q <= rf_rdata;
            end
            // Flags move at the end of EXEC so the new value is visible during WB.
            if (state_q == ST_EXEC) begin
                result_q   <= wb_val;
                sr_flags_q <= new_flags;
            end
        end
    end

    assign sr_flags = sr_flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed table, back-to-back and reset sequences, then random instructions.
// Owns a synchronous-read register file and a combinational ALU model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_sel;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  sr_flags;
    logic        done, err;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .sr_flags    (sr_flags),
        .done        (done),
        .err         (err)
    );

    logic [15:0] regs [16];

    always @(posedge clk) rf_rdata <= regs[rf_raddr];

    // ALU model; logic ops return deliberately wrong flags so pass-through would be caught.
    always_comb begin
        logic [16:0] w;
        w          = 17'h0;
        alu_result = 16'h0000;
        alu_flags  = 4'h0;
        case (alu_sel)
            5'b00000: begin
                w          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = w[15:0];
                alu_flags  = {w[15], w[15:0] == 16'h0, w[16],
                              (alu_a[15] == alu_b[15]) && (w[15] != alu_a[15])};
            end
            5'b00001, 5'b01001: begin
                w          = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
                alu_result = w[15:0];
                alu_flags  = {w[15], w[15:0] == 16'h0, w[16],
                              (alu_a[15] != alu_b[15]) && (w[15] != alu_a[15])};
            end
            5'b00011, 5'b00110: alu_result = alu_a & alu_b;
            5'b00100:           alu_result = alu_a ^ alu_b;
            5'b00111:           alu_result = ~alu_a & alu_b;
            5'b01000:           alu_result = alu_a | alu_b;
            default:            alu_result = 16'h0000;
        endcase
        if (alu_sel inside {5'b00011, 5'b00110, 5'b00100, 5'b00111, 5'b01000}) begin
            alu_flags = {~alu_result[15], alu_result != 16'h0, alu_result == 16'h0, 1'b1};
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_instr(input logic [15:0] ins, output int dk, output logic err_s,
                             output int we_cnt, output logic [15:0] wd_s, output logic [3:0] wa_s,
                             output logic [3:0] fl_s, output logic [15:0] a_s, output logic [15:0] b_s,
                             output logic [4:0] sel_s, output int rdy_low);
        dk = -1; err_s = 1'b0; we_cnt = 0; wd_s = '0; wa_s = '0; fl_s = '0;
        a_s = '0; b_s = '0; sel_s = '0; rdy_low = 0;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) instr_valid = 1'b0;
            if (!instr_ready) rdy_low++;
            if (k == 2) begin
                a_s = alu_a; b_s = alu_b; sel_s = alu_sel;
            end
            if (rf_we) begin
                we_cnt++; wd_s = rf_wdata; wa_s = rf_waddr;
            end
            if (done && dk < 0) begin
                dk = k; err_s = err; fl_s = sr_flags;
            end
        end
        if (dk < 0) fl_s = sr_flags;
    endtask

    // Architectural reference: what one instruction should do, from the ISA rules.
    function automatic void ref_model(input logic [15:0] ins, input logic [15:0] sv, input logic [15:0] dv,
                                      input logic [3:0] fin, output logic legal, output logic wr,
                                      output logic [15:0] wd, output logic [3:0] fout);
        logic [3:0]  op;
        logic        bw, c, v, n, z;
        logic [15:0] s, d, r;
        int          kind;
        op = ins[15:12]; bw = ins[6];
        s = bw ? (sv & 16'h00FF) : sv;
        d = bw ? (dv & 16'h00FF) : dv;
        c = 1'b0; v = 1'b0; kind = 0; r = 16'h0;
        legal = (op inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF})
                && !ins[7] && (ins[5:4] == 2'b00);
        case (op)
            4'h4: r = s;
            4'h5: begin
                r = d + s; kind = 1;
                c = (32'(d) + 32'(s)) > 32'h0000FFFF;
                v = (d[15] == s[15]) && (r[15] != d[15]);
            end
            4'h8, 4'h9: begin
                r = d - s; kind = 1;
                c = (d >= s);
                v = (d[15] != s[15]) && (r[15] != d[15]);
            end
            4'hB, 4'hF: begin r = d & s; kind = 2; end
            4'hE:       begin r = d ^ s; kind = 2; end
            4'hC:       r = ~s & d;
            4'hD:       r = s | d;
            default:    r = 16'h0;
        endcase
        wd = bw ? {8'h00, r[7:0]} : r;
        n  = bw ? r[7] : r[15];
        z  = bw ? (r[7:0] == 8'h00) : (r == 16'h0);
        fout = fin;
        if (legal && kind == 1) fout = {n, z, c, v};
        if (legal && kind == 2) fout = {n, z, ~z, 1'b0};
        wr = legal && (op != 4'h9) && (op != 4'hB);
    endfunction

    typedef struct {
        logic [15:0] ins, sv, dv;
        logic        e_err;
        int          e_dk;
        int          e_we;
        logic [15:0] e_wd;
        logic [3:0]  e_fl;
        logic        chk_alu;
        logic [15:0] e_a, e_b;
        logic [4:0]  e_sel;
    } vec_t;

    vec_t        vecs [15];
    int          dk, we_cnt, rdy_low;
    logic        e_s, legal, wr;
    logic [15:0] wd_s, a_s, b_s, exp_wd, rins;
    logic [3:0]  wa_s, fl_s, model_fl, exp_fl;
    logic [4:0]  sel_s;
    logic [9:0]  done_mask, rdy_mask;
    int          rst_we, rst_done;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{16'h5405, 16'h1234, 16'h0F0F, 1'b0, 3, 1, 16'h2143, 4'b0000, 1'b1, 16'h0F0F, 16'h1234, 5'b00000};
        vecs[1]  = '{16'h9405, 16'h1234, 16'h1234, 1'b0, 3, 0, 16'h0000, 4'b0110, 1'b1, 16'h1234, 16'h1234, 5'b01001};
        vecs[2]  = '{16'h5445, 16'h00FF, 16'h0001, 1'b0, 3, 1, 16'h0000, 4'b0100, 1'b1, 16'h0001, 16'h00FF, 5'b00000};
        vecs[3]  = '{16'hC405, 16'h00F0, 16'hFFFF, 1'b0, 3, 1, 16'hFF0F, 4'b0100, 1'b1, 16'h00F0, 16'hFFFF, 5'b00111};
        vecs[4]  = '{16'h5485, 16'h1111, 16'h2222, 1'b1, 0, 0, 16'h0000, 4'b0100, 1'b1, 16'h0000, 16'h0000, 5'b00000};
        vecs[5]  = '{16'hE405, 16'hFFFF, 16'h8000, 1'b0, 3, 1, 16'h7FFF, 4'b0010, 1'b1, 16'h8000, 16'hFFFF, 5'b00100};
        vecs[6]  = '{16'hF405, 16'h00FF, 16'h0F00, 1'b0, 3, 1, 16'h0000, 4'b0100, 1'b1, 16'h0F00, 16'h00FF, 5'b00011};
        vecs[7]  = '{16'hB405, 16'h8000, 16'h8001, 1'b0, 3, 0, 16'h0000, 4'b1010, 1'b1, 16'h8001, 16'h8000, 5'b00110};
        vecs[8]  = '{16'h4405, 16'hABCD, 16'h0000, 1'b0, 3, 1, 16'hABCD, 4'b1010, 1'b0, 16'h0000, 16'h0000, 5'b00000};
        vecs[9]  = '{16'h8405, 16'h0001, 16'h0000, 1'b0, 3, 1, 16'hFFFF, 4'b1000, 1'b1, 16'h0000, 16'h0001, 5'b00001};
        vecs[10] = '{16'hD445, 16'h12F0, 16'h340F, 1'b0, 3, 1, 16'h00FF, 4'b1000, 1'b1, 16'h000F, 16'h00F0, 5'b01000};
        vecs[11] = '{16'h6405, 16'h1111, 16'h2222, 1'b1, 0, 0, 16'h0000, 4'b1000, 1'b0, 16'h0000, 16'h0000, 5'b00000};
        vecs[12] = '{16'h5415, 16'h1111, 16'h2222, 1'b1, 0, 0, 16'h0000, 4'b1000, 1'b0, 16'h0000, 16'h0000, 5'b00000};
        vecs[13] = '{16'h5505, 16'h4000, 16'h4000, 1'b0, 3, 1, 16'h8000, 4'b1001, 1'b1, 16'h4000, 16'h4000, 5'b00000};
        vecs[14] = '{16'h0405, 16'h1111, 16'h2222, 1'b1, 0, 0, 16'h0000, 4'b1001, 1'b0, 16'h0000, 16'h0000, 5'b00000};

        for (int r = 0; r < 16; r++) regs[r] = 16'h0000;
        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst instr_ready", 32'(instr_ready), 32'd1);
        chk("rst rf_we",       32'(rf_we),       32'd0);
        chk("rst done",        32'(done),        32'd0);
        chk("rst err",         32'(err),         32'd0);
        chk("rst sr_flags",    32'(sr_flags),    32'd0);
        chk("rst rf_raddr",    32'(rf_raddr),    32'd0);
        chk("rst rf_waddr",    32'(rf_waddr),    32'd0);
        chk("rst rf_wdata",    32'(rf_wdata),    32'd0);
        chk("rst alu_a",       32'(alu_a),       32'd0);
        chk("rst alu_b",       32'(alu_b),       32'd0);
        chk("rst alu_sel",     32'(alu_sel),     32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            regs[vecs[i].ins[11:8]] = vecs[i].sv;
            regs[vecs[i].ins[3:0]]  = vecs[i].dv;
            run_instr(vecs[i].ins, dk, e_s, we_cnt, wd_s, wa_s, fl_s, a_s, b_s, sel_s, rdy_low);
            chk($sformatf("vec%0d done_cycle", i), 32'(dk), 32'(vecs[i].e_dk));
            chk($sformatf("vec%0d err", i), 32'(e_s), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d rf_we_count", i), 32'(we_cnt), 32'(vecs[i].e_we));
            if (vecs[i].e_we != 0) begin
                chk($sformatf("vec%0d rf_wdata", i), 32'(wd_s), 32'(vecs[i].e_wd));
                chk($sformatf("vec%0d rf_waddr", i), 32'(wa_s), 32'(vecs[i].ins[3:0]));
            end
            chk($sformatf("vec%0d sr_flags", i), 32'(fl_s), 32'(vecs[i].e_fl));
            chk($sformatf("vec%0d ready_low", i), 32'(rdy_low), vecs[i].e_err ? 32'd1 : 32'd4);
            if (vecs[i].chk_alu) begin
                chk($sformatf("vec%0d alu_a", i), 32'(a_s), 32'(vecs[i].e_a));
                chk($sformatf("vec%0d alu_b", i), 32'(b_s), 32'(vecs[i].e_b));
                chk($sformatf("vec%0d alu_sel", i), 32'(sel_s), 32'(vecs[i].e_sel));
            end
        end

        // Valid held high: second accept only once the first has retired.
        regs[4] = 16'h1234; regs[5] = 16'h0F0F;
        @(negedge clk);
        instr = 16'h5405; instr_valid = 1'b1;
        @(posedge clk);
        done_mask = '0; rdy_mask = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) done_mask[k] = 1'b1;
            if (!instr_ready) rdy_mask[k] = 1'b1;
            if (k == 9) instr_valid = 1'b0;
        end
        chk("b2b done pulses", 32'(done_mask), 32'h108);
        chk("b2b ready low",   32'(rdy_mask),  32'h1EF);

        // Reset in EXEC with nonzero flags: no write, flags cleared, next instruction clean.
        regs[4] = 16'h1234; regs[5] = 16'h1234;
        run_instr(16'h9405, dk, e_s, we_cnt, wd_s, wa_s, fl_s, a_s, b_s, sel_s, rdy_low);
        chk("pre-reset cmp flags", 32'(fl_s), 32'b0110);
        regs[5] = 16'h0F0F;
        @(negedge clk);
        instr = 16'h5405; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst instr_ready", 32'(instr_ready), 32'd1);
        chk("midrst rf_we",       32'(rf_we),       32'd0);
        chk("midrst done",        32'(done),        32'd0);
        chk("midrst sr_flags",    32'(sr_flags),    32'd0);
        chk("midrst alu_sel",     32'(alu_sel),     32'd0);
        rst_we = 0; rst_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (rf_we) rst_we++;
            if (done) rst_done++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rf_we) rst_we++;
            if (done) rst_done++;
        end
        chk("midrst no write", 32'(rst_we), 32'd0);
        chk("midrst no done",  32'(rst_done), 32'd0);
        run_instr(16'h5405, dk, e_s, we_cnt, wd_s, wa_s, fl_s, a_s, b_s, sel_s, rdy_low);
        chk("postrst done_cycle", 32'(dk), 32'd3);
        chk("postrst rf_wdata",   32'(wd_s), 32'h2143);
        chk("postrst rf_waddr",   32'(wa_s), 32'd5);
        chk("postrst sr_flags",   32'(fl_s), 32'd0);

        model_fl = 4'b0000;
        for (int j = 0; j < 300; j++) begin
            for (int r = 0; r < 16; r++) regs[r] = 16'($urandom);
            rins = {4'($urandom_range(0, 15)), 4'($urandom),
                    ($urandom_range(0, 7) == 0), 1'($urandom),
                    ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    4'($urandom)};
            ref_model(rins, regs[rins[11:8]], regs[rins[3:0]], model_fl, legal, wr, exp_wd, exp_fl);
            run_instr(rins, dk, e_s, we_cnt, wd_s, wa_s, fl_s, a_s, b_s, sel_s, rdy_low);
            chk($sformatf("rnd%0d(%h) done_cycle", j, rins), 32'(dk), legal ? 32'd3 : 32'd0);
            chk($sformatf("rnd%0d(%h) err", j, rins), 32'(e_s), 32'(!legal));
            chk($sformatf("rnd%0d(%h) rf_we_count", j, rins), 32'(we_cnt), wr ? 32'd1 : 32'd0);
            if (wr) begin
                chk($sformatf("rnd%0d(%h) rf_wdata", j, rins), 32'(wd_s), 32'(exp_wd));
                chk($sformatf("rnd%0d(%h) rf_waddr", j, rins), 32'(wa_s), 32'(rins[3:0]));
            end
            chk($sformatf("rnd%0d(%h) sr_flags", j, rins), 32'(fl_s), 32'(exp_fl));
            model_fl = exp_fl;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
